// File: rtl/mult_seq_unit.sv
// ---------------------------------------------------------------------------
// mult_seq_unit
//   Multi-cycle shift-add integer multiplier for the execute stage. A mult
//   issued from execute latches rs/rt, retires BITS_PER_CYCLE multiplier bits
//   per clock and delivers the 2*WIDTH product as {hi, lo}. busy/done let the
//   hazard unit stall dependent mfhi/mflo and new mults until hi/lo are valid.
//
//   Parameters
//     WIDTH          operand width (product is 2*WIDTH bits)
//     BITS_PER_CYCLE multiplier bits retired per clock: 1, 2 or 4, dividing WIDTH
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous, active-low reset
//     start      request a multiply (accepted in IDLE and DONE)
//     is_signed  two's-complement operands (only with MULT_SIGNED_EN)
//     a, b       multiplicand (rs), multiplier (rt)
//     busy       high exactly while the operation runs (N cycles)
//     done       one-cycle pulse when hi/lo take a new product
//     hi, lo     upper/lower half of the last completed product
//
//   Build option
//     MULT_SIGNED_EN  adds is_signed; magnitudes are multiplied and the
//                     product is negated on completion when signs differ.
// ---------------------------------------------------------------------------
module mult_seq_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef MULT_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int PW    = 2 * WIDTH;
  // Accumulator carries BITS_PER_CYCLE extra bits so a partial sum never wraps.
  localparam int AW    = PW + BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   mcand_reg, mcand_next;    // multiplicand, shifted left each step
  logic [WIDTH-1:0] mplier_reg, mplier_next; // multiplier, shifted right each step
  logic [AW-1:0]   acc_reg, acc_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            neg_reg, neg_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             op_neg;
  logic [AW-1:0]    partial;
  logic [AW-1:0]    sum;
  logic [PW-1:0]    product;

  // Operand conditioning: unsigned operands pass straight through; signed
  // operands are reduced to magnitudes and the result sign is remembered.
`ifdef MULT_SIGNED_EN
  logic sign_a, sign_b;
  assign sign_a = is_signed & a[WIDTH-1];
  assign sign_b = is_signed & b[WIDTH-1];
  assign a_mag  = sign_a ? -a : a;
  assign b_mag  = sign_b ? -b : b;
  assign op_neg = sign_a ^ sign_b;
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign op_neg = 1'b0;
`endif

  // One shifted copy of the multiplicand per retired multiplier bit.
  logic [AW-1:0] term [BITS_PER_CYCLE];
  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
      assign term[gi] = mplier_reg[gi] ? (AW'(mcand_reg) << gi) : '0;
    end
  endgenerate

  always_comb begin
    partial = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      partial = partial + term[k];
    end
  end

  assign sum     = acc_reg + partial;
  assign product = neg_reg ? -sum[PW-1:0] : sum[PW-1:0];

  // Next-state / datapath logic
  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    count_next  = count_reg;
    neg_next    = neg_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          mcand_next  = PW'(a_mag);
          mplier_next = b_mag;
          acc_next    = '0;
          count_next  = CW'(STEPS);
          neg_next    = op_neg;
          state_next  = RUN;
        end else begin
          state_next  = IDLE;
        end
      end
      RUN: begin
        acc_next    = sum;
        mcand_next  = mcand_reg << BITS_PER_CYCLE;
        mplier_next = mplier_reg >> BITS_PER_CYCLE;
        count_next  = count_reg - 1'b1;
        // Last step: the product including this step's partial sum is final.
        if (count_reg == CW'(1)) begin
          {hi_next, lo_next} = product;
          state_next         = DONE;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      neg_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      count_reg  <= count_next;
      neg_reg    <= neg_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_unit
//   Directed bench for mult_seq_unit: one instance with BITS_PER_CYCLE=1 and
//   one with BITS_PER_CYCLE=4, both WIDTH=32. Expected values are hand
//   computed constants.
// ---------------------------------------------------------------------------
module tb_mult_seq_unit;

  logic        clk;
  logic        rst;
  logic        start1, start4;
  logic        is_signed;
  logic [31:0] a, b;
  logic        busy1, done1, busy4, done4;
  logic [31:0] hi1, lo1, hi4, lo4;

  int n_checks = 0;
  int n_pass   = 0;
  int lat, bcnt, dcnt;

  mult_seq_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
`ifdef MULT_SIGNED_EN
    .is_signed(is_signed),
`endif
    .a(a), .b(b), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
  );

  mult_seq_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
`ifdef MULT_SIGNED_EN
    .is_signed(is_signed),
`endif
    .a(a), .b(b), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Called right after the accepting edge; returns cycles until done and the
  // number of sampled cycles with busy high before done.
  task automatic run(input bit wide, output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while ((wide ? done4 : done1) !== 1'b1 && cycles < 200) begin
      if ((wide ? busy4 : busy1) === 1'b1) busy_cycles++;
      tick();
      cycles++;
    end
  endtask

  initial begin
    rst = 1'b0; start1 = 1'b0; start4 = 1'b0; is_signed = 1'b0;
    a = '0; b = '0;
    tick(); tick();
    // Reset state
    check("reset_busy", 64'(busy1), 64'd0);
    check("reset_done", 64'(done1), 64'd0);
    check("reset_hilo", {hi1, lo1}, 64'd0);
    check("reset_hilo4", {hi4, lo4}, 64'd0);
    rst = 1'b1;
    tick();

    // Basic 7*6
    a = 32'd7; b = 32'd6; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("basic_busy_after_accept", {62'd0, busy1, done1}, 64'd2);
    check("basic_hilo_unchanged_on_accept", {hi1, lo1}, 64'd0);
    run(1'b0, lat, bcnt);
    check("basic_latency", 64'(lat), 64'd32);
    check("basic_busy_cycles", 64'(bcnt), 64'd32);
    check("basic_done_busy", {62'd0, busy1, done1}, 64'd1);
    check("basic_product", {hi1, lo1}, 64'h0000_0000_0000_002A);
    tick();
    check("basic_after_done", {62'd0, busy1, done1}, 64'd0);
    tick();
    check("basic_hilo_held", {hi1, lo1}, 64'h0000_0000_0000_002A);

    // Full-width operands, BPC=1
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    run(1'b0, lat, bcnt);
    check("full_latency", 64'(lat), 64'd32);
    check("full_product", {hi1, lo1}, 64'hFFFF_FFFE_0000_0001);
    tick();

    // Full-width operands, BPC=4
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    run(1'b1, lat, bcnt);
    check("full4_latency", 64'(lat), 64'd8);
    check("full4_busy_cycles", 64'(bcnt), 64'd8);
    check("full4_product", {hi4, lo4}, 64'hFFFF_FFFE_0000_0001);
    tick();
    check("full4_after_done", {62'd0, busy4, done4}, 64'd0);

    // BPC=4 carry into hi: 0x10000 * 0x10000
    a = 32'h0001_0000; b = 32'h0001_0000; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    run(1'b1, lat, bcnt);
    check("pow4_product", {hi4, lo4}, 64'h0000_0001_0000_0000);
    tick();

    // Start ignored while busy: 3*5, stray 9*9 at cycle 10
    a = 32'd3; b = 32'd5; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    a = 32'd9; b = 32'd9; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("ignore_busy_still", 64'(busy1), 64'd1);
    run(1'b0, lat, bcnt);
    check("ignore_latency", 64'(lat), 64'd22);
    check("ignore_product", {hi1, lo1}, 64'h0000_0000_0000_000F);
    tick();
    check("ignore_idle", {62'd0, busy1, done1}, 64'd0);
    tick();
    check("ignore_no_restart", 64'(busy1), 64'd0);

    // Reset mid-operation
    a = 32'h1234; b = 32'h10; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b0;
    tick();
    check("abort_busy_done", {62'd0, busy1, done1}, 64'd0);
    check("abort_hilo", {hi1, lo1}, 64'd0);
    rst = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done1 === 1'b1 || busy1 === 1'b1) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);

    // Back-to-back: 2*3 then 4*5 accepted in the DONE cycle
    a = 32'd2; b = 32'd3; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    run(1'b0, lat, bcnt);
    check("b2b_first_product", {hi1, lo1}, 64'd6);
    a = 32'd4; b = 32'd5; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("b2b_busy_next", {62'd0, busy1, done1}, 64'd2);
    check("b2b_hilo_held_during_run", {hi1, lo1}, 64'd6);
    run(1'b0, lat, bcnt);
    check("b2b_latency", 64'(lat), 64'd32);
    check("b2b_second_product", {hi1, lo1}, 64'h14);
    tick();

`ifdef MULT_SIGNED_EN
    // Signed -3 * 5
    is_signed = 1'b1; a = 32'hFFFF_FFFD; b = 32'd5; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    run(1'b0, lat, bcnt);
    check("signed_latency", 64'(lat), 64'd32);
    check("signed_product", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFF1);
    tick();
    // Same operands unsigned
    is_signed = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    run(1'b0, lat, bcnt);
    check("unsigned_product", {hi1, lo1}, 64'h0000_0004_FFFF_FFF1);
    tick();
    // Signed -3 * -5 on BPC=4
    is_signed = 1'b1; a = 32'hFFFF_FFFD; b = 32'hFFFF_FFFB; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    is_signed = 1'b0;
    run(1'b1, lat, bcnt);
    check("signed4_product", {hi4, lo4}, 64'd15);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_seq_unit.md
Name: mult_seq_unit

Overview:
- Multi-cycle shift-add integer multiplier for the execute stage; replaces the single-cycle combinational multiplier.
- Takes rs/rt operands from execute when a mult instruction issues.
- Produces the 64-bit {hi, lo} product that is carried through memory and write-back into the HI/LO registers.
- Exposes busy/done so hazard control stalls dependent mfhi/mflo and new mults until the product is valid.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- BITS_PER_CYCLE, 1, multiplier bits retired per cycle. Legal values are 1, 2, 4, and must divide WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  request a multiply; sampled every rising edge.
- a  input  WIDTH  multiplicand (rs).
- b  input  WIDTH  multiplier (rt).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when hi/lo take a new product.
- hi  output  WIDTH  upper half of the last completed product.
- lo  output  WIDTH  lower half of the last completed product.

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - Internal accumulator, shifted-operand registers and counter are cleared.
  - Reset overrides every other input and aborts any operation mid-flight; no done pulse is produced for an aborted operation.
- States: IDLE, RUN, DONE.
- IDLE / DONE:
  - start==1 at an edge: latch a and b, clear the accumulator, set count=WIDTH/BITS_PER_CYCLE, go to RUN.
  - Otherwise IDLE stays IDLE, and DONE goes to IDLE.
- RUN:
  - Each edge retires BITS_PER_CYCLE low bits of the multiplier register: add the corresponding shifted multiplicand multiples into the 2*WIDTH accumulator, shift, decrement count.
  - The edge on which count becomes 0 writes {hi,lo}=product and goes to DONE.
  - start is ignored in RUN; operands already latched are unaffected.
- Outputs:
  - busy is a registered output, 1 exactly in RUN.
  - done is a registered output, 1 exactly in DONE (a single cycle).
- Latency: with N=WIDTH/BITS_PER_CYCLE, the product and done are visible N cycles after the edge that accepted start, and busy is high for those N cycles.
- No early exit: zero or small operands take the full N cycles.
- hi/lo hold the last product indefinitely. They change only on the completing RUN edge or on reset, never on start acceptance.
- start in the DONE cycle is accepted (back-to-back operation). The previous hi/lo stay valid during that DONE cycle.
- Arithmetic is unsigned modulo 2^(2*WIDTH). The internal accumulator must not overflow, i.e. it needs full 2*WIDTH+BITS_PER_CYCLE headroom for carries.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit), sampled together with start.
  - When is_signed=1, operands are treated as two's complement. Magnitudes are latched, the sign XOR is stored, and the final product is negated on the completing edge if the signs differ.
  - Latency is unchanged.
  - When is_signed=0, or in the undefined build, behaviour is unsigned (multu).
- Undefined: the port is absent and all multiplies are unsigned.

Test Plan:
- Basic multiply: reset, then start with a=7, b=6 (WIDTH=32, BPC=1) -> busy=1 for 32 cycles; done pulses on the 32nd cycle with hi=0x00000000, lo=0x0000002A; busy=0 afterward; hi/lo held.
- Full-width operands: start with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Repeat with BITS_PER_CYCLE=4 -> same result, done after 8 cycles.
- Start ignored while busy: start 3*5; at cycle 10 pulse start with a=9, b=9 -> ignored; result hi=0, lo=0x0000000F at cycle 32, then state returns to IDLE.
- Reset mid-operation: start 0x1234*0x10; rst=0 at cycle 5 -> busy=0, done=0, hi=lo=0; no done pulse follows.
- Back-to-back: start 2*3, then assert start with a=4, b=5 in the done cycle -> lo=6 visible in that cycle, busy=1 next cycle, lo=0x14 32 cycles later.
- Signed (MULT_SIGNED_EN): is_signed=1, a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Same operands with is_signed=0 -> hi=0x00000004, lo=0xFFFFFFF1.
